// File: rtl/decimate_pkg.sv
// Shared helpers for the decimating round-robin merger: counter sizing and
// the round-robin priority search used by the arbiter.
package decimate_pkg;

  localparam int MAX_N   = 64;
  localparam int MAX_LOG = 6;

  function automatic int cw(input int m);
    return ($clog2(m) > 1) ? $clog2(m) : 1;
  endfunction

  // Returns the first requesting index after ptr (wrapping at n), or -1.
  // Walks the distance downward so the closest requester is written last.
  function automatic int rr_next(input logic [MAX_N-1:0] req, input int ptr, input int n);
    int res;
    int idx;
    res = -1;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[MAX_LOG-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, pointer advances on adv.
module rr_arbiter
  import decimate_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0]    ptr;
  logic [MAX_N-1:0] req_ext;
  int               nxt;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    nxt            = rr_next(req_ext, int'(ptr), N);
    gnt            = '0;
    idx            = '0;
    for (int i = 0; i < N; i++) gnt[i] = (nxt == i);
    for (int i = 0; i < N; i++) if (gnt[i]) idx = IW'(i);
  end

  // ptr = N-1 after reset so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst)      ptr <= IW'(N - 1);
    else if (adv) ptr <= idx;
  end

endmodule

// File: rtl/decimate_arbiter.sv
// Per-channel keep-every-M-th decimation merged round-robin onto one
// registered output port tagged with the source channel.
module decimate_arbiter
  import decimate_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int N  = 4,
  parameter  int M  = 2,
  localparam int CW = cw(M),
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   en,
  input  logic [N-1:0]   s_stb,
  input  logic [N*W-1:0] s_dat,
  output logic [N-1:0]   s_rdy,
  input  logic           m_rdy,
  output logic           m_stb,
  output logic [W-1:0]   m_dat,
  output logic [IW-1:0]  m_chn
);

  localparam logic [CW-1:0] KEEP_AT = CW'(M - 1);

  logic [CW-1:0] cnt [N];
  logic [N-1:0]  keep;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] idx;
  logic          load;
  logic [W-1:0]  sel_dat;

  always_comb begin
    for (int i = 0; i < N; i++) keep[i] = (cnt[i] == KEEP_AT);
  end

  // A transfer happens on a port in any cycle where stb and rdy are both 1;
  // stb holds its data until then and rdy never waits on stb being low.
  // Dropping channels are always ready; keeping channels only when they win
  // the arbiter in a cycle where the output register loads.
  assign req   = en & s_stb & keep & {N{~rst}};
  assign load  = ~rst & (~m_stb | m_rdy) & (|req);
  assign s_rdy = en & {N{~rst}} & (~keep | (gnt & {N{load}}));

  rr_arbiter #(.N(N)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (load),
    .gnt (gnt),
    .idx (idx)
  );

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < N; i++) if (gnt[i]) sel_dat = s_dat[i*W +: W];
  end

  // Disabling a channel zeroes its phase so re-enable restarts the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst || !en[i])            cnt[i] <= '0;
      else if (s_stb[i] && s_rdy[i]) cnt[i] <= keep[i] ? '0 : cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_stb <= 1'b0;
      m_dat <= '0;
      m_chn <= '0;
    end else if (load) begin
      m_stb <= 1'b1;
      m_dat <= sel_dat;
      m_chn <= idx;
    end else if (m_rdy) begin
      m_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decimate_arbiter.sv
// Directed bench for decimate_arbiter: three instances (M=3, M=2, M=1) share
// one stimulus set; each vector names which instance it checks.
module tb_decimate_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   en = '0;
  logic [N-1:0]   s_stb = '0;
  logic [N*W-1:0] s_dat = '0;
  logic           m_rdy = 1'b0;

  logic [N-1:0] rdy_a, rdy_b, rdy_c;
  logic         stb_a, stb_b, stb_c;
  logic [W-1:0] dat_a, dat_b, dat_c;
  logic [1:0]   chn_a, chn_b, chn_c;

  always #5 clk = ~clk;

  decimate_arbiter #(.W(W), .N(N), .M(3)) dut_m3 (
    .clk(clk), .rst(rst), .en(en), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(rdy_a),
    .m_rdy(m_rdy), .m_stb(stb_a), .m_dat(dat_a), .m_chn(chn_a));

  decimate_arbiter #(.W(W), .N(N), .M(2)) dut_m2 (
    .clk(clk), .rst(rst), .en(en), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(rdy_b),
    .m_rdy(m_rdy), .m_stb(stb_b), .m_dat(dat_b), .m_chn(chn_b));

  decimate_arbiter #(.W(W), .N(N), .M(1)) dut_m1 (
    .clk(clk), .rst(rst), .en(en), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(rdy_c),
    .m_rdy(m_rdy), .m_stb(stb_c), .m_dat(dat_c), .m_chn(chn_c));

  typedef struct {
    int          sel;      // 0: M=3, 1: M=2, 2: M=1
    logic        rst;
    logic [3:0]  en;
    logic [3:0]  stb;
    logic [63:0] dat;
    logic        m_rdy;
    logic [3:0]  exp_rdy;
    logic        exp_stb;
    logic [15:0] exp_dat;
    logic [1:0]  exp_chn;
  } vec_t;

  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;
  string tag = "";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int sel, input logic r, input logic [3:0] e,
                              input logic [3:0] s, input logic [63:0] d, input logic mr,
                              input logic [3:0] er, input logic es, input logic [15:0] ed,
                              input logic [1:0] ec);
    vec_t v;
    v.sel = sel; v.rst = r; v.en = e; v.stb = s; v.dat = d; v.m_rdy = mr;
    v.exp_rdy = er; v.exp_stb = es; v.exp_dat = ed; v.exp_chn = ec;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [3:0]  r;
    logic        s;
    logic [15:0] d;
    logic [1:0]  c;
    @(negedge clk);
    rst = v.rst; en = v.en; s_stb = v.stb; s_dat = v.dat; m_rdy = v.m_rdy;
    #1;
    r = (v.sel == 0) ? rdy_a : (v.sel == 1) ? rdy_b : rdy_c;
    check("s_rdy", 64'(r), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    s = (v.sel == 0) ? stb_a : (v.sel == 1) ? stb_b : stb_c;
    d = (v.sel == 0) ? dat_a : (v.sel == 1) ? dat_b : dat_c;
    c = (v.sel == 0) ? chn_a : (v.sel == 1) ? chn_b : chn_c;
    check("m_stb", 64'(s), 64'(v.exp_stb));
    if (v.exp_stb) begin
      check("m_dat", 64'(d), 64'(v.exp_dat));
      check("m_chn", 64'(c), 64'(v.exp_chn));
    end
  endtask

  task automatic add_reset(input int sel);
    for (int k = 0; k < 2; k++)
      vecs.push_back(mk(sel, 1, 4'hF, 4'hF, 64'h0, 1, 4'h0, 0, 16'h0, 2'd0));
  endtask

  initial begin
    // Reset state of all three instances, with enables and strobes high.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1; en = '1; s_stb = '1; s_dat = {4{16'hFFFF}}; m_rdy = 1'b1;
      #1;
      tag = $sformatf("reset%0d", k);
      check("rdy_m3", 64'(rdy_a), 64'h0);
      check("rdy_m2", 64'(rdy_b), 64'h0);
      check("rdy_m1", 64'(rdy_c), 64'h0);
      @(posedge clk);
      #1;
      check("stb_m3", 64'(stb_a), 64'h0);
      check("stb_m2", 64'(stb_b), 64'h0);
      check("stb_m1", 64'(stb_c), 64'h0);
      check("dat_m2", 64'(dat_b), 64'h0);
      check("chn_m2", 64'(chn_b), 64'h0);
    end

    // Single channel, M=3: samples 1..9 on ch0, kept every third.
    add_reset(0);
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk(0, 0, 4'h1, 4'h1, 64'(k), 1, 4'h1, (k % 3 == 0), 16'(k), 2'd0));
    vecs.push_back(mk(0, 0, 4'h1, 4'h0, 64'h0, 1, 4'h1, 0, 16'h0, 2'd0));

    // All four channels streaming, M=2: rotation 0,1,2,3 with no bubbles.
    add_reset(1);
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0031_0021_0011_0001, 1, 4'hF, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0032_0022_0012_0002, 1, 4'h1, 1, 16'h0002, 2'd0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0032_0022_0012_0003, 1, 4'h3, 1, 16'h0012, 2'd1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0032_0022_0013_0004, 1, 4'h6, 1, 16'h0022, 2'd2));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0032_0023_0014_0004, 1, 4'hC, 1, 16'h0032, 2'd3));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0033_0024_0014_0004, 1, 4'h9, 1, 16'h0004, 2'd0));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0034_0024_0014_0005, 1, 4'h3, 1, 16'h0014, 2'd1));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0034_0024_0015_0006, 1, 4'h6, 1, 16'h0024, 2'd2));
    vecs.push_back(mk(1, 0, 4'hF, 4'hF, 64'h0034_0025_0016_0006, 1, 4'hC, 1, 16'h0034, 2'd3));

    // Backpressure, M=2: ch0 occupies the output while ch1/ch2 keeps wait.
    add_reset(1);
    vecs.push_back(mk(1, 0, 4'h7, 4'h7, 64'h0000_0C01_0B01_0A01, 1, 4'h7, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(1, 0, 4'h7, 4'h7, 64'h0000_0C02_0B02_0A02, 0, 4'h1, 1, 16'h0A02, 2'd0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 4'h7, 4'h6, 64'h0000_0C02_0B02_0A02, 0, 4'h1, 1, 16'h0A02, 2'd0));
    vecs.push_back(mk(1, 0, 4'h7, 4'h6, 64'h0000_0C02_0B02_0A02, 1, 4'h3, 1, 16'h0B02, 2'd1));
    vecs.push_back(mk(1, 0, 4'h7, 4'h4, 64'h0000_0C02_0B02_0A02, 1, 4'h7, 1, 16'h0C02, 2'd2));
    vecs.push_back(mk(1, 0, 4'h7, 4'h0, 64'h0000_0C02_0B02_0A02, 1, 4'h7, 0, 16'h0000, 2'd0));

    // Disable/re-enable ch2, M=3: phase restarts, only 12 is kept.
    add_reset(0);
    vecs.push_back(mk(0, 0, 4'h4, 4'h4, 64'h0000_0009_0000_0000, 1, 4'h4, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h4, 64'h0000_0099_0000_0000, 1, 4'h0, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(0, 0, 4'h4, 4'h4, 64'h0000_000A_0000_0000, 1, 4'h4, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(0, 0, 4'h4, 4'h4, 64'h0000_000B_0000_0000, 1, 4'h4, 0, 16'h0000, 2'd0));
    vecs.push_back(mk(0, 0, 4'h4, 4'h4, 64'h0000_000C_0000_0000, 1, 4'h4, 1, 16'h000C, 2'd2));
    vecs.push_back(mk(0, 0, 4'h4, 4'h0, 64'h0000_0000_0000_0000, 1, 4'h4, 0, 16'h0000, 2'd0));

    // M=1: one sample per channel at once, drained in order 0..3.
    add_reset(2);
    vecs.push_back(mk(2, 0, 4'hF, 4'hF, 64'h0044_0033_0022_0011, 1, 4'h1, 1, 16'h0011, 2'd0));
    vecs.push_back(mk(2, 0, 4'hF, 4'hE, 64'h0044_0033_0022_0011, 1, 4'h2, 1, 16'h0022, 2'd1));
    vecs.push_back(mk(2, 0, 4'hF, 4'hC, 64'h0044_0033_0022_0011, 1, 4'h4, 1, 16'h0033, 2'd2));
    vecs.push_back(mk(2, 0, 4'hF, 4'h8, 64'h0044_0033_0022_0011, 1, 4'h8, 1, 16'h0044, 2'd3));
    vecs.push_back(mk(2, 0, 4'hF, 4'h0, 64'h0044_0033_0022_0011, 1, 4'h0, 0, 16'h0000, 2'd0));

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      apply(vecs[i]);
    end

    // Reset mid-operation, M=2: m_stb=1 and cnt[0]=1 when rst hits; ptr was 1,
    // so a stale pointer would pick ch2 instead of ch0 afterwards.
    tag = "rstmid";
    apply(mk(1, 1, 4'h7, 4'h7, 64'h0, 1, 4'h0, 0, 16'h0000, 2'd0));
    apply(mk(1, 0, 4'h7, 4'h7, 64'h0000_0C01_0B01_0A01, 1, 4'h7, 0, 16'h0000, 2'd0));
    apply(mk(1, 0, 4'h7, 4'h2, 64'h0000_0C02_0B02_0A02, 0, 4'h2, 1, 16'h0B02, 2'd1));
    apply(mk(1, 1, 4'h7, 4'h7, 64'h0000_0C02_0B02_0A02, 0, 4'h0, 0, 16'h0000, 2'd0));
    apply(mk(1, 0, 4'h7, 4'h7, 64'h0000_0C01_0B01_0A01, 1, 4'h7, 0, 16'h0000, 2'd0));
    apply(mk(1, 0, 4'h7, 4'h7, 64'h0000_0C02_0B02_0A02, 1, 4'h1, 1, 16'h0A02, 2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimate_arbiter.md
# decimate_arbiter

Shares one decimated output stream among N input streams. Each channel keeps every M-th sample and drops the rest. Kept samples from all channels are merged round-robin onto a single registered master port, tagged with their channel index. The block sits between the per-channel sample sources and the single downstream consumer that `decimate` would otherwise feed, one instance per channel.

## Interface
- `W`, 16: sample width in bits.
- `N`, 4: number of input channels, ≥2.
- `M`, 2: decimation factor, ≥1. Counter width is `CW = max(1, $clog2(M))`.

- `clk`  in  1  : system clock; all state updates on the rising edge.
- `rst`  in  1  : reset, synchronous and active-high.
- `en`  in  N  : per-channel enable; bit i gates channel i.
- `s_stb`  in  N  : per-channel sample strobe.
- `s_dat`  in  N*W  : channel i sample at `[i*W +: W]`.
- `s_rdy`  out  N  : per-channel ready.
- `m_rdy`  in  1  : downstream ready.
- `m_stb`  out  1  : output sample valid.
- `m_dat`  out  W  : output sample.
- `m_chn`  out  `$clog2(N)`  : source channel of `m_dat`.

## Operation
- **Per-channel counter `cnt[i]`**, range 0..M-1.
  - A channel is *keeping* when `cnt[i] == M-1`; otherwise it is *dropping*.
- **Dropping channel** (`en[i]=1`):
  - `s_rdy[i]=1`.
  - Each `s_stb[i]&s_rdy[i]` discards the sample and increments `cnt[i]`.
- **Keeping channel** (`en[i]=1`):
  - It requests the arbiter when `s_stb[i]=1`.
  - `s_rdy[i]=1` only in the cycle it is granted and the output register loads.
  - On that handshake `cnt[i]` returns to 0.
  - M=1: every channel is permanently keeping, so every sample is forwarded.
- **Disabled channel** (`en[i]=0`):
  - `s_rdy[i]=0`, `cnt[i]` forced to 0, never requests.
  - Re-enabling restarts the phase: the M-th accepted sample after enable is the first kept.
- **Arbiter**, round-robin over requesting channels.
  - Search starts at `ptr+1` (mod N), where `ptr` is the last granted channel.
  - `ptr` updates only on a load.
  - Fair: with all N requesting continuously, each channel gets exactly one grant per N loads.
- **Output register** (`m_stb`, `m_dat`, `m_chn`):
  - Loads when `~m_stb | m_rdy` and any request is present.
  - `m_stb` clears on `m_stb & m_rdy` with no new load.
  - `m_dat`/`m_chn` hold while `m_stb & ~m_rdy`.
- **Simultaneous events:**
  - A drain (`m_stb & m_rdy`) and a new load in the same cycle give back-to-back output with no bubble.
  - Dropping-channel increments in other channels proceed in parallel with a grant.

## Timing
- Reset values: `m_stb=0`, `m_dat=0`, `m_chn=0`, all `cnt=0`, `ptr=N-1` (channel 0 has first priority).
- `s_rdy` is combinational from `cnt`, `en`, `s_stb`, `m_stb`, `m_rdy`. There is no combinational path from `s_dat` to any output.
- Latency: a kept sample handshaken in cycle t appears with `m_stb=1` in cycle t+1.
- Throughput: one output per cycle when `m_rdy=1` continuously.
- `rst` asserted mid-transfer: any pending `m_stb` sample is discarded, and all counters and `ptr` return to reset values the following cycle.
- `s_rdy` is 0 in every cycle with `rst=1`.

## Structure
- Shared package `decimate_pkg`:
  - function `cw(M)` returning counter width.
  - function `rr_next(req, ptr)` for the round-robin priority search.
- One sub-module `rr_arbiter` (parameter N):
  - inputs `req[N]`, `adv`.
  - outputs one-hot `gnt[N]` and binary `idx`.
  - owns `ptr`; the synchronous reset sets `ptr=N-1`.
- The top holds the counter array, request generation and the output register.

## Test plan
- **Single channel** (N=4, M=3): ch0 sends 1..9, `m_rdy=1`, others idle → output 3,6,9 with `m_chn=0`, each one cycle after its handshake.
- **All four channels** (M=2) stream continuously, `m_rdy=1` → output channels 0,1,2,3,0,1,… with no bubbles. Each channel's kept values are its 2nd, 4th, … samples.
- **Backpressure:**
  - Hold `m_rdy=0` for 5 cycles with a keep pending on ch1 and ch2.
  - Required: `m_stb`/`m_dat`/`m_chn` stable throughout, `s_rdy[1]=s_rdy[2]=0`.
  - On release, ch1 then ch2 are output on consecutive cycles.
- **Disable:**
  - Clear `en[2]` after ch2 has accepted one sample (M=3). Required: `s_rdy[2]=0`.
  - Re-enable and send 10,11,12. Required: output 12 only.
- **M=1:** four channels each send one sample in the same cycle → 4 outputs over 4 cycles in order 0,1,2,3.
- **Reset mid-operation:** assert `rst` while `m_stb=1` and `cnt[0]=1` → next cycle `m_stb=0`. After release the first grant goes to ch0, and ch0's counter restarts from 0.
